// File: rtl/fb_line_prefetch_if.sv
// SDRAM read-burst and pixel-FIFO write signals shared by the line prefetcher
// and its neighbours.
interface fb_line_prefetch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 24
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ack;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  fifo_empty;

    modport master (
        output req, req_addr, fifo_wr_en, fifo_data,
        input  req_ack, rd_valid, rd_data, fifo_rd_en, fifo_empty
    );

    modport slave (
        input  req, req_addr, fifo_wr_en, fifo_data,
        output req_ack, rd_valid, rd_data, fifo_rd_en, fifo_empty
    );
endinterface

// File: rtl/fb_line_prefetch.sv
// Framebuffer line prefetcher: walks the frame in fixed SDRAM bursts and only requests
// a burst once the pixel FIFO is guaranteed a free slot for every beat.
module fb_line_prefetch #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned FB_BASE     = 0,
    parameter int unsigned FRAME_WORDS = 76800
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   frame_start,
    fb_line_prefetch_if.master     bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   proto_err
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned WW = $clog2(FRAME_WORDS + 1);

    localparam logic [CW-1:0]         BurstCredits = CW'(BURST_LEN);
    localparam logic [CW-1:0]         FullCredits  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0]         BeatLast     = BW'(BURST_LEN - 1);
    localparam logic [WW-1:0]         BurstWords   = WW'(BURST_LEN);
    localparam logic [WW-1:0]         FrameWords   = WW'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BaseAddr     = ADDR_WIDTH'(FB_BASE);
    localparam logic [ADDR_WIDTH-1:0] BurstStride  = ADDR_WIDTH'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StWaitCredit, StReq, StData} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [WW-1:0]         word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  err_q;

    logic accept, pop, last_beat, frame_end;

    assign accept    = (state_q == StReq) && bus.req_ack;
    // A pop of an empty FIFO still frees a slot when it coincides with our write.
    assign pop       = bus.fifo_rd_en && (!bus.fifo_empty || wr_en_q);
    assign last_beat = (state_q == StData) && bus.rd_valid && (beat_q == BeatLast);
    assign frame_end = last_beat && ((word_q + BurstWords) == FrameWords);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        beat_d    = beat_q;
        credits_d = credits_q + {{(CW-1){1'b0}}, pop} - (accept ? BurstCredits : '0);
        unique case (state_q)
            StIdle: begin
                if (frame_start && enable) begin
                    state_d = StWaitCredit;
                    addr_d  = BaseAddr;
                    word_d  = '0;
                end
            end
            StWaitCredit: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (credits_q >= BurstCredits) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.req_ack) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (bus.rd_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        addr_d  = addr_q + BurstStride;
                        word_d  = word_q + BurstWords;
                        state_d = (frame_end || !enable) ? StIdle : StWaitCredit;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            credits_q <= FullCredits;
            beat_q    <= '0;
            word_q    <= '0;
            addr_q    <= BaseAddr;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            wr_en_q   <= bus.rd_valid && (state_q == StData);
            data_q    <= bus.rd_data;
            done_q    <= frame_end;
            err_q     <= err_q || (bus.rd_valid && (state_q != StData));
        end
    end

    assign bus.req        = (state_q == StReq);
    assign bus.req_addr   = addr_q;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_data  = data_q;
    assign busy           = (state_q != StIdle);
    assign frame_done     = done_q;
    assign proto_err      = err_q;

    credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credits_q <= FullCredits);
endmodule

// File: tb/tb_fb_line_prefetch.sv
// Directed bench for fb_line_prefetch: a vector table for a full two-burst frame plus
// hand sequences for credit starvation, enable drop, protocol error and async reset.
module tb_fb_line_prefetch;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 24;
    localparam int unsigned BASE = 'h100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic          req_ack = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en = 1'b0;
    logic          busy_a, done_a, perr_a, busy_b, done_b, perr_b;
    int            occ_a, occ_b;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    fb_line_prefetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    fb_line_prefetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.req_ack    = req_ack;
    assign bus_a.rd_valid   = rd_valid;
    assign bus_a.rd_data    = rd_data;
    assign bus_a.fifo_rd_en = rd_en;
    assign bus_a.fifo_empty = (occ_a == 0);
    assign bus_b.req_ack    = req_ack;
    assign bus_b.rd_valid   = rd_valid;
    assign bus_b.rd_data    = rd_data;
    assign bus_b.fifo_rd_en = rd_en;
    assign bus_b.fifo_empty = (occ_b == 0);

    // Instance A: two-burst frame. Instance B: longer frame so it can starve on credits.
    fb_line_prefetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(8), .FIFO_DEPTH(16),
        .FB_BASE(BASE), .FRAME_WORDS(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .bus(bus_a), .busy(busy_a), .frame_done(done_a), .proto_err(perr_a)
    );

    fb_line_prefetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(8), .FIFO_DEPTH(16),
        .FB_BASE(BASE), .FRAME_WORDS(64)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .bus(bus_b), .busy(busy_b), .frame_done(done_b), .proto_err(perr_b)
    );

    // Occupancy models of the downstream FIFOs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_a <= 0;
            occ_b <= 0;
        end else begin
            occ_a <= occ_a + int'(bus_a.fifo_wr_en)
                     - int'(rd_en && (occ_a != 0 || bus_a.fifo_wr_en));
            occ_b <= occ_b + int'(bus_b.fifo_wr_en)
                     - int'(rd_en && (occ_b != 0 || bus_b.fifo_wr_en));
        end
    end

    typedef struct {
        logic          fs, en, ack, rv;
        logic [DW-1:0] data;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          exp_wr;
        logic [DW-1:0] exp_data;
        logic          exp_busy, exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DW-1:0] beat(int k);
        return 32'hA5A5_0000 + DW'(k);
    endfunction

    function automatic vec_t mk(logic fs, logic en, logic ack, logic rv, logic [DW-1:0] data,
                                logic r, logic [AW-1:0] a, logic w, logic [DW-1:0] d,
                                logic b, logic dn);
        vec_t v;
        v.fs = fs; v.en = en; v.ack = ack; v.rv = rv; v.data = data;
        v.exp_req = r; v.exp_addr = a; v.exp_wr = w; v.exp_data = d;
        v.exp_busy = b; v.exp_done = dn;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {enable, frame_start, req_ack, rd_valid, rd_en} = '0;
        rd_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        chk("reset req", 64'(bus_a.req), 0);
        chk("reset addr", 64'(bus_a.req_addr), BASE);
        chk("reset wr_en", 64'(bus_a.fifo_wr_en), 0);
        chk("reset data", 64'(bus_a.fifo_data), 0);
        chk("reset busy", 64'(busy_a), 0);
        chk("reset done", 64'(done_a), 0);
        chk("reset perr", 64'(perr_a), 0);
        chk("reset credits", 64'(u_dut_a.credits_q), 16);

        // Full frame on A, consumer popping continuously, ack two cycles after req
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, AW'(BASE), 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, AW'(BASE), 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, AW'(BASE), 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, AW'(BASE), 0, 0, 1, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 1, 0, 1, beat(k), 0, AW'(k == 7 ? BASE + 8 : BASE),
                              1, beat(k), 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, AW'(BASE + 8), 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, AW'(BASE + 8), 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, AW'(BASE + 8), 0, 0, 1, 0));
        for (int k = 8; k < 16; k++)
            vecs.push_back(mk(0, 1, 0, 1, beat(k), 0, AW'(k == 15 ? BASE + 16 : BASE + 8),
                              1, beat(k), k != 15, k == 15));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, AW'(BASE + 16), 0, 0, 0, 0));

        rd_en = 1'b1;
        foreach (vecs[i]) begin
            frame_start = vecs[i].fs;
            enable      = vecs[i].en;
            req_ack     = vecs[i].ack;
            rd_valid    = vecs[i].rv;
            rd_data     = vecs[i].data;
            tick();
            chk($sformatf("v%0d req", i), 64'(bus_a.req), 64'(vecs[i].exp_req));
            chk($sformatf("v%0d addr", i), 64'(bus_a.req_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("v%0d wr_en", i), 64'(bus_a.fifo_wr_en), 64'(vecs[i].exp_wr));
            if (vecs[i].exp_wr)
                chk($sformatf("v%0d data", i), 64'(bus_a.fifo_data), 64'(vecs[i].exp_data));
            chk($sformatf("v%0d busy", i), 64'(busy_a), 64'(vecs[i].exp_busy));
            chk($sformatf("v%0d done", i), 64'(done_a), 64'(vecs[i].exp_done));
        end
        tick();
        chk("frame credits", 64'(u_dut_a.credits_q), 16);
        chk("frame perr", 64'(perr_a), 0);

        // Credit starvation on B: no pops, two bursts fill the 16-deep FIFO
        do_reset();
        enable = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("starve req1", 64'(bus_b.req), 1);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_valid = 1'b1;
            rd_data = beat(k);
            tick();
        end
        rd_valid = 1'b0;
        chk("starve credits8", 64'(u_dut_b.credits_q), 8);
        tick();
        chk("starve req2", 64'(bus_b.req), 1);
        chk("starve addr2", 64'(bus_b.req_addr), BASE + 8);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_valid = 1'b1;
            rd_data = beat(k + 8);
            tick();
        end
        rd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("parked req %0d", k), 64'(bus_b.req), 0);
            chk($sformatf("parked busy %0d", k), 64'(busy_b), 1);
        end
        chk("parked credits", 64'(u_dut_b.credits_q), 0);
        rd_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("pop%0d req", k + 1), 64'(bus_b.req), 0);
        end
        chk("pop7 credits", 64'(u_dut_b.credits_q), 7);
        tick();
        rd_en = 1'b0;
        chk("pop8 req", 64'(bus_b.req), 0);
        chk("pop8 credits", 64'(u_dut_b.credits_q), 8);
        tick();
        chk("after pop8 req", 64'(bus_b.req), 1);
        chk("after pop8 addr", 64'(bus_b.req_addr), BASE + 16);

        // Acceptance and pop in the same edge with credits at 8
        rd_en = 1'b1;
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        rd_en = 1'b0;
        chk("ack+pop credits", 64'(u_dut_b.credits_q), 1);
        chk("ack+pop req", 64'(bus_b.req), 0);

        // Enable dropped at beat 3 on A: burst completes, no frame_done
        do_reset();
        rd_en = 1'b1;
        enable = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            enable = (k < 3);
            rd_valid = 1'b1;
            rd_data = beat(k);
            tick();
            chk($sformatf("drop wr%0d", k), 64'(bus_a.fifo_wr_en), 1);
            chk($sformatf("drop data%0d", k), 64'(bus_a.fifo_data), 64'(beat(k)));
        end
        rd_valid = 1'b0;
        chk("drop busy", 64'(busy_a), 0);
        chk("drop done", 64'(done_a), 0);
        tick();
        chk("drop done2", 64'(done_a), 0);
        chk("drop req", 64'(bus_a.req), 0);

        // rd_valid while idle, frame_start while disabled
        do_reset();
        rd_valid = 1'b1;
        rd_data = beat(99);
        tick();
        rd_valid = 1'b0;
        chk("idle beat wr", 64'(bus_a.fifo_wr_en), 0);
        chk("idle beat perr", 64'(perr_a), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("disabled start busy", 64'(busy_a), 0);
        tick();
        chk("perr sticky", 64'(perr_a), 1);
        do_reset();
        chk("perr cleared", 64'(perr_a), 0);

        // Asynchronous reset mid-burst at beat 4
        rd_en = 1'b1;
        enable = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_valid = 1'b1;
            rd_data = beat(k);
            tick();
        end
        rd_data = beat(4);
        chk("pre-reset busy", 64'(busy_a), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async req", 64'(bus_a.req), 0);
        chk("async addr", 64'(bus_a.req_addr), BASE);
        chk("async wr_en", 64'(bus_a.fifo_wr_en), 0);
        chk("async data", 64'(bus_a.fifo_data), 0);
        chk("async busy", 64'(busy_a), 0);
        chk("async done", 64'(done_a), 0);
        chk("async perr", 64'(perr_a), 0);
        rd_valid = 1'b0;
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("async credits", 64'(u_dut_a.credits_q), 16);
        chk("async busy after", 64'(busy_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
